// File: rtl/rr_decoder.sv
// rr_decoder: routes index tokens from one input channel to N dataless output channels
// through a 2-entry FIFO. Define RR_DECODER_ERRCNT_EN to add the saturating err_count port.
module rr_decoder #(
    parameter int unsigned N    = 4,
    parameter int unsigned NIdx = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_v,
    input  logic [NIdx-1:0] in_d,
    output logic            in_a,
`ifdef RR_DECODER_ERRCNT_EN
    output logic [7:0]      err_count,
`endif
    input  logic [N-1:0]    out_a,
    output logic [N-1:0]    out_v
);

    logic [NIdx-1:0] fifo_q [2];
    logic            head_q;
    logic            tail_q;
    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic            in_a_q;
    logic            take;
    logic            in_range;
    logic            push;
    logic            pop;

    assign take     = in_v && in_a_q;
    assign in_range = 32'(in_d) < N;
    assign push     = take && in_range;
    // Only the head destination can have out_v high, so other acks are masked off here.
    assign pop      = |(out_v & out_a);
    assign in_a     = in_a_q;

    always_comb begin
        out_v = '0;
        for (int unsigned i = 0; i < N; i++) begin
            out_v[i] = (count_q != 2'd0) && (32'(fifo_q[head_q]) == i);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // in_a is registered from the next occupancy so it never depends on in_v or out_a.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            in_a_q    <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= in_d;
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_d;
            in_a_q  <= (count_d != 2'd2);
        end
    end

`ifdef RR_DECODER_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 8'd0;
        end else if (take && !in_range && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: doc/rr_decoder.md
# rr_decoder

Receive side of the round-robin arbitration path: it takes a data-carrying `Channel` whose data word is a source index and routes each token to the matching `DatalessChannel` in an output array. It buffers tokens in a two-entry FIFO so that no combinational path exists from any output ack to the input ack. It sits downstream of an N-way round-robin arbiter (or its off-chip equivalent) and reconstitutes the per-source event lines.

## Interface
- `N`, default 4: number of output channels, must be ≥ 2.
- `NIdx`, default `$clog2(N)`: width of the index carried on `in.d`.
- `clk  input  1  clock; all state changes on the rising edge.`
- `reset  input  1  asynchronous, active-low reset; state clears immediately while low.`
- `in.v  input  1  index token valid.`
- `in.d  input  NIdx  destination index.`
- `in.a  output  1  ack; a token transfers on a rising edge where in.v && in.a.`
- `out[i].v  output  1 each (N total)  token pending for destination i.`
- `out[i].a  input  1 each (N total)  ack from destination i; transfer on edge where out[i].v && out[i].a.`
- `err_count  output  8  saturating count of out-of-range indices (only with RR_DECODER_ERRCNT_EN).`

## Operation
- Storage: 2-entry FIFO of NIdx-bit indices, with head pointer, tail pointer and a 2-bit occupancy count.
- `in.a = (count != 2)`. It is a pure function of registered state and never depends on `in.v` or any `out[i].a`.
- Push happens on an edge with `in.v && in.a && (in.d < N)`. The index is written at tail, and tail increments mod 2.
- Out-of-range token (`in.d >= N`, possible only when N is not a power of 2): it is still acked and consumed. It is not enqueued and produces no output activity.
- `out[i].v = (count != 0) && (fifo[head] == i)`. At most one `out[i].v` is high at any time.
- Pop happens on an edge where `out[fifo[head]].a` is high and count is nonzero. Head increments mod 2.
- Any `out[j].a` with `out[j].v` low is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at count 1. At count 2 no push occurs because `in.a` is low.
- Occupancy transitions: 0 → 1 on push. 1 → 2 on push without pop. 2 → 1 on pop. 1 → 0 on pop without push.
- Sender contract: `in.v` and `in.d` hold stable until acked. Receiver contract: `out[i].v` and `fifo[head]` hold stable until popped.

## Timing
- Reset low: count = 0, head = tail = 0, `in.a` = 0, all `out[i].v` = 0, `err_count` = 0. All of these take effect asynchronously.
- First edge after reset rises: `in.a` = 1.
- Latency: a token accepted at edge k drives `out[d].v` high from just after edge k. It is visible in cycle k+1 and never in the same cycle it is offered.
- Throughput: one token per cycle sustained when the destination acks every cycle. With a stalled head, two tokens are accepted, then `in.a` drops until a pop.
- `in.a` rises in the cycle after the pop edge that frees a slot. There is no same-cycle pass-through.
- Reset asserted mid-transfer: all buffered tokens are discarded, and outputs drop without waiting for acks.

## Configuration
- `RR_DECODER_ERRCNT_EN` defined: the `err_count` port exists.
  - It increments by 1 on each edge that consumes an out-of-range token.
  - It saturates at 255 and resets to 0.
- Not defined: the `err_count` port and counter are absent. Out-of-range tokens are silently dropped (still acked).

## Test plan
- Reset, then single token: N=4, release reset, send `in.d`=2 with destination 2 acking immediately. Require `in.a`=0 during reset. Require `out[2].v` high exactly one cycle after acceptance, a single pop, and all `out[i].v` low afterwards.
- Stalled head: N=4, send 1, 3, 0 with `out[1].a` held low.
  - Require `in.a` low after two accepts, with token 0 still pending at input.
  - Release `out[1].a` for one cycle. Require `out[3].v` next, and `in.a` high the following cycle.
- Back-to-back streaming: N=4, 64 random in-range indices with all acks tied high. Require one transfer per cycle and in-order delivery matching the input sequence exactly.
- Out-of-range index: N=3, send 3 then 1. Require the 3 to be acked with no `out[*].v`, then `out[1].v` to follow. With the macro, require `err_count`=1.
- Saturation: N=3, with the macro, send 300 tokens of index 3. Require `err_count`=255 and never wrap.
- Reset mid-operation: two tokens buffered with acks low, assert reset for one cycle. Require immediate `out[*].v`=0 and count 0, and no stale token delivered after reset rises.
